// File: rtl/pwm_cfg_sequencer.sv
// pwm_cfg_sequencer
//   Period-synchronous configuration controller for the fast PWM generator.
//   A host configuration (period top, two duty compares, ramp flag) is taken
//   through a valid/ready handshake into shadow registers and applied to the
//   PWM only on the edge that ends a PWM period. With ramp enabled, each duty
//   moves toward its target by at most RAMP_STEP per period.
//
// Ports
//   clk, reset_n             shared clock, asynchronous active-low reset
//   cfg_valid / cfg_ready    host handshake, one configuration outstanding
//   cfg_top/cnta/cntb/ramp   requested configuration, sampled at accept
//   timer_top, pwm_cnta/b    registered settings driven into the PWM
//   period_tick              high in the last cycle of every PWM period
//   busy                     a configuration is pending or ramping
module pwm_cfg_sequencer #(
  parameter int WIDTH     = 32,
  parameter int RAMP_STEP = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_top,
  input  logic [WIDTH-1:0] cfg_cnta,
  input  logic [WIDTH-1:0] cfg_cntb,
  input  logic             cfg_ramp,
  output logic [WIDTH-1:0] timer_top,
  output logic [WIDTH-1:0] pwm_cnta,
  output logic [WIDTH-1:0] pwm_cntb,
  output logic             period_tick,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, PEND, RAMP} state_t;

  localparam logic signed [WIDTH:0] STEP_S = (WIDTH+1)'(RAMP_STEP);
  localparam logic        [WIDTH-1:0] STEP_U = WIDTH'(RAMP_STEP);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] tgt_top, tgt_a, tgt_b;
  logic             tgt_ramp;
  logic [WIDTH-1:0] top_nxt, a_nxt, b_nxt;
  logic             load_tgt;

  // Move cur toward tgt by at most RAMP_STEP. The difference is taken one bit
  // wider and signed so that large moves in either direction never wrap.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    logic signed [WIDTH:0] diff;
    diff = $signed({1'b0, tgt}) - $signed({1'b0, cur});
    if (diff > STEP_S)
      step_toward = cur + STEP_U;
    else if (diff < -STEP_S)
      step_toward = cur - STEP_U;
    else
      step_toward = tgt;
  endfunction

  // Mirror of the PWM counter: same rule and same top register keep both aligned.
  assign period_tick = (cnt >= timer_top);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    top_nxt   = timer_top;
    a_nxt     = pwm_cnta;
    b_nxt     = pwm_cntb;
    cfg_ready = 1'b0;
    busy      = 1'b1;
    load_tgt  = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        busy      = 1'b0;
        if (cfg_valid) begin
          load_tgt  = 1'b1;
          state_nxt = PEND;
        end
      end
      PEND, RAMP: begin
        // The accept-cycle boundary is skipped naturally: we are still in IDLE then.
        if (period_tick) begin
          top_nxt = tgt_top;
          if (!tgt_ramp) begin
            a_nxt = tgt_a;
            b_nxt = tgt_b;
          end else begin
            a_nxt = step_toward(pwm_cnta, tgt_a);
            b_nxt = step_toward(pwm_cntb, tgt_b);
          end
          if (a_nxt == tgt_a && b_nxt == tgt_b)
            state_nxt = IDLE;
          else
            state_nxt = RAMP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt       <= '0;
      timer_top <= '0;
      pwm_cnta  <= '0;
      pwm_cntb  <= '0;
      tgt_top   <= '0;
      tgt_a     <= '0;
      tgt_b     <= '0;
      tgt_ramp  <= 1'b0;
    end else begin
      // Uses the old top, so the counter wraps on the same edge the top changes.
      cnt       <= (cnt < timer_top) ? cnt + 1'b1 : '0;
      timer_top <= top_nxt;
      pwm_cnta  <= a_nxt;
      pwm_cntb  <= b_nxt;
      if (load_tgt) begin
        tgt_top  <= cfg_top;
        tgt_a    <= cfg_cnta;
        tgt_b    <= cfg_cntb;
        tgt_ramp <= cfg_ramp;
      end
    end
  end

endmodule
